// File: rtl/booth_seq_mult_hilo.sv
// Sequential signed radix-2 Booth multiplier, one step per clock, HI/LO result.
// Ports: clock, clear (sync, active-low), start, a, b -> busy, done, hi_out, lo_out.
module booth_seq_mult_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH:0]   m_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_nxt;
  logic             qm1_q;
  logic             qm1_nxt;
  logic [CW-1:0]    cnt_q;
  logic             last;

  assign last = (cnt_q == CW'(1));

  // One Booth step: add/sub M, then arithmetic shift of {A,Q,q_m1}.
  always_comb begin
    sum = acc_q;
    unique case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + m_q;
      2'b10:   sum = acc_q - m_q;
      default: sum = acc_q;
    endcase
    acc_nxt = {sum[WIDTH], sum[WIDTH:1]};
    q_nxt   = {sum[0], q_q[WIDTH-1:1]};
    qm1_nxt = q_q[0];
  end

  always_ff @(posedge clock) begin
    if (!clear) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      m_q    <= '0;
      acc_q  <= '0;
      q_q    <= '0;
      qm1_q  <= 1'b0;
      cnt_q  <= '0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            m_q   <= {a[WIDTH-1], a};
            acc_q <= '0;
            q_q   <= b;
            qm1_q <= 1'b0;
            cnt_q <= CW'(WIDTH);
          end
        end
        RUN: begin
          acc_q <= acc_nxt;
          q_q   <= q_nxt;
          qm1_q <= qm1_nxt;
          cnt_q <= cnt_q - 1'b1;
          if (last) begin
            hi_out <= acc_nxt[WIDTH-1:0];
            lo_out <= q_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
